// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, instruction fetch and IR hold for the multi-cycle TSC CPU
module instr_fetch_unit #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_inputReady,
    output logic [WORD_SIZE-1:0] instr,
    output logic                 instr_valid,
    input  logic                 instr_accept,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 halt,
    output logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] pc_plus1,
    output logic [WORD_SIZE-1:0] fetch_count
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_next_state;
    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] r_ir;
    logic [WORD_SIZE-1:0] r_count;
    logic [WORD_SIZE-1:0] w_pc_inc;
    logic                 w_load_ir;
    logic                 w_retire;

    assign w_pc_inc  = r_pc + ONE;
    assign w_load_ir = (r_state == S_REQ) && i_inputReady;
    assign w_retire  = (r_state == S_VALID) && instr_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_INIT;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load_ir) begin
                r_ir <= i_data;
            end
            if (w_retire) begin
                r_count <= r_count + ONE;
                // A halting instruction keeps pc pointing at the HLT itself
                if (!halt) begin
                    r_pc <= redirect ? redirect_pc : w_pc_inc;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT:  w_next_state = S_REQ;
            S_REQ:   if (i_inputReady) w_next_state = S_VALID;
            S_VALID: if (instr_accept) w_next_state = halt ? S_HALT : S_REQ;
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_INIT;
        endcase
    end

    assign i_readM     = (r_state == S_REQ);
    assign instr_valid = (r_state == S_VALID);
    assign i_address   = r_pc;
    assign pc          = r_pc;
    assign pc_plus1    = w_pc_inc;
    assign instr       = r_ir;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data = '0;
    logic        i_inputReady = 1'b0;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_accept = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic [15:0] fetch_count;

    logic        b_reset = 1'b1;
    logic        b_readM;
    logic [7:0]  b_address;
    logic [7:0]  b_instr;
    logic        b_valid;
    logic        b_accept = 1'b0;
    logic [7:0]  b_pc;
    logic [7:0]  b_pc_plus1;
    logic [7:0]  b_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .i_readM(i_readM), .i_address(i_address), .i_data(i_data), .i_inputReady(i_inputReady),
        .instr(instr), .instr_valid(instr_valid), .instr_accept(instr_accept),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .pc(pc), .pc_plus1(pc_plus1), .fetch_count(fetch_count)
    );

    // Narrow instance so the fetch_count wrap is reachable in a few hundred cycles
    instr_fetch_unit #(.WORD_SIZE(8), .RESET_PC(8'hFF)) dut_w (
        .clk(clk), .reset(b_reset),
        .i_readM(b_readM), .i_address(b_address), .i_data(8'h5C), .i_inputReady(1'b1),
        .instr(b_instr), .instr_valid(b_valid), .instr_accept(b_accept),
        .redirect(1'b0), .redirect_pc(8'h00), .halt(1'b0),
        .pc(b_pc), .pc_plus1(b_pc_plus1), .fetch_count(b_count)
    );

    typedef struct {
        int          lat;
        logic [15:0] data;
        logic        red;
        logic [15:0] rpc;
        logic [15:0] exp_addr;
        logic [15:0] exp_next;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] memf(input logic [15:0] a);
        logic [31:0] p;
        p = {16'h0, a} * 32'h9E37;
        return p[15:0] ^ 16'h5A5A;
    endfunction

    task automatic wait_readm(input int budget, input string name);
        int n;
        n = 0;
        while (!i_readM && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'h0, i_readM}, 32'h1);
    endtask

    // Waits lat cycles with noise on ignored inputs, then returns data for one cycle
    task automatic fetch(input int lat, input logic [15:0] d);
        repeat (lat) begin
            redirect     = 1'($urandom);
            halt         = 1'($urandom);
            instr_accept = 1'($urandom);
            redirect_pc  = 16'($urandom);
            @(negedge clk);
        end
        redirect = 1'b0; halt = 1'b0; instr_accept = 1'b0;
        i_inputReady = 1'b1; i_data = d;
        @(negedge clk);
        i_inputReady = 1'b0; i_data = 16'($urandom);
    endtask

    task automatic accept(input logic r, input logic [15:0] rp, input logic h);
        instr_accept = 1'b1; redirect = r; redirect_pc = rp; halt = h;
        @(negedge clk);
        instr_accept = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 16'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] m_pc;
        logic [15:0] m_cnt;
        logic [15:0] hold_pc;
        logic [15:0] hold_ir;
        logic [7:0]  b_exp_pc;
        logic        r;
        logic [15:0] rp;
        int          n;

        tbl[0] = '{0, 16'h1234, 1'b0, 16'h0000, 16'h0001, 16'h0002};
        tbl[1] = '{3, 16'hA5A5, 1'b0, 16'h0000, 16'h0002, 16'h0003};
        tbl[2] = '{1, 16'h0F0F, 1'b0, 16'h0000, 16'h0003, 16'h0004};
        tbl[3] = '{0, 16'h7777, 1'b0, 16'h0000, 16'h0004, 16'h0005};
        tbl[4] = '{2, 16'h2222, 1'b1, 16'h0020, 16'h0005, 16'h0020};
        tbl[5] = '{1, 16'hB00B, 1'b1, 16'hFFFF, 16'h0020, 16'hFFFF};
        tbl[6] = '{0, 16'h4321, 1'b0, 16'h0000, 16'hFFFF, 16'h0000};
        tbl[7] = '{4, 16'hFACE, 1'b0, 16'h0000, 16'h0000, 16'h0001};

        @(negedge clk);
        chk("rst_readM", {31'h0, i_readM}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_pc", {16'h0, pc}, 32'h0);
        chk("rst_instr", {16'h0, instr}, 32'h0);
        chk("rst_count", {16'h0, fetch_count}, 32'h0);
        reset = 1'b0;

        @(negedge clk);
        chk("first_req", {31'h0, i_readM}, 32'h1);
        chk("first_addr", {16'h0, i_address}, 32'h0);
        fetch(2, 16'h6001);
        chk("first_valid", {31'h0, instr_valid}, 32'h1);
        chk("first_instr", {16'h0, instr}, 32'h6001);
        chk("first_readM_lo", {31'h0, i_readM}, 32'h0);
        accept(1'b0, 16'h0000, 1'b0);
        chk("seq_pc", {16'h0, pc}, 32'h0001);
        chk("seq_readM", {31'h0, i_readM}, 32'h1);
        chk("seq_count", {16'h0, fetch_count}, 32'h1);

        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tbl%0d_addr", i), {16'h0, i_address}, {16'h0, tbl[i].exp_addr});
            chk($sformatf("tbl%0d_plus1", i), {16'h0, pc_plus1}, {16'h0, 16'(tbl[i].exp_addr + 16'h1)});
            fetch(tbl[i].lat, tbl[i].data);
            chk($sformatf("tbl%0d_instr", i), {16'h0, instr}, {16'h0, tbl[i].data});
            chk($sformatf("tbl%0d_valid", i), {31'h0, instr_valid}, 32'h1);
            chk($sformatf("tbl%0d_cnt", i), {16'h0, fetch_count}, i + 1);
            accept(tbl[i].red, tbl[i].rpc, 1'b0);
            chk($sformatf("tbl%0d_next", i), {16'h0, pc}, {16'h0, tbl[i].exp_next});
            chk($sformatf("tbl%0d_req", i), {31'h0, i_readM}, 32'h1);
        end

        // Redirect and accept while requesting must not move pc
        redirect = 1'b1; redirect_pc = 16'h0040; instr_accept = 1'b1;
        repeat (2) @(negedge clk);
        redirect = 1'b0; instr_accept = 1'b0;
        chk("req_redirect_pc", {16'h0, pc}, 32'h0001);
        chk("req_redirect_cnt", {16'h0, fetch_count}, 32'd9);
        fetch(0, 16'h9999);
        redirect = 1'b1; redirect_pc = 16'h0040; halt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_inputReady = k[0]; i_data = 16'hDEAD;
            @(negedge clk);
            chk($sformatf("stall%0d_instr", k), {16'h0, instr}, 32'h9999);
            chk($sformatf("stall%0d_pc", k), {16'h0, pc}, 32'h0001);
            chk($sformatf("stall%0d_cnt", k), {16'h0, fetch_count}, 32'd9);
            chk($sformatf("stall%0d_readM", k), {31'h0, i_readM}, 32'h0);
        end
        redirect = 1'b0; halt = 1'b0; i_inputReady = 1'b0;
        accept(1'b0, 16'h0000, 1'b0);

        m_pc  = 16'h0002;
        m_cnt = 16'd10;
        for (int k = 0; k < 150; k++) begin
            wait_readm(5, "rnd_req");
            chk("rnd_addr", {16'h0, i_address}, {16'h0, m_pc});
            fetch(int'($urandom_range(0, 3)), memf(m_pc));
            n = int'($urandom_range(0, 3));
            repeat (n) begin
                i_inputReady = 1'($urandom);
                @(negedge clk);
            end
            i_inputReady = 1'b0;
            chk("rnd_instr", {16'h0, instr}, {16'h0, memf(m_pc)});
            chk("rnd_cnt", {16'h0, fetch_count}, {16'h0, m_cnt});
            r  = ($urandom_range(0, 3) == 0);
            rp = 16'($urandom);
            accept(r, rp, 1'b0);
            m_cnt = m_cnt + 16'h1;
            m_pc  = r ? rp : m_pc + 16'h1;
            chk("rnd_pc", {16'h0, pc}, {16'h0, m_pc});
        end

        wait_readm(5, "halt_req");
        fetch(1, 16'hF01D);
        accept(1'b1, 16'h0030, 1'b1);
        chk("halt_readM", {31'h0, i_readM}, 32'h0);
        chk("halt_valid", {31'h0, instr_valid}, 32'h0);
        chk("halt_pc", {16'h0, pc}, {16'h0, m_pc});
        chk("halt_cnt", {16'h0, fetch_count}, {16'h0, 16'(m_cnt + 16'h1)});
        for (int k = 0; k < 20; k++) begin
            i_inputReady = 1'($urandom); instr_accept = 1'($urandom);
            redirect = 1'($urandom); redirect_pc = 16'h0030;
            @(negedge clk);
            chk("halt_no_req", {31'h0, i_readM}, 32'h0);
        end
        i_inputReady = 1'b0; instr_accept = 1'b0; redirect = 1'b0;
        chk("halt_hold_pc", {16'h0, pc}, {16'h0, m_pc});
        chk("halt_hold_instr", {16'h0, instr}, 32'hF01D);
        chk("halt_hold_cnt", {16'h0, fetch_count}, {16'h0, 16'(m_cnt + 16'h1)});

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_pre_req", {31'h0, i_readM}, 32'h1);
        #2;
        reset = 1'b1; i_inputReady = 1'b1; i_data = 16'hBEEF;
        #1;
        chk("mid_readM_drop", {31'h0, i_readM}, 32'h0);
        chk("mid_pc", {16'h0, pc}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        i_inputReady = 1'b0;
        chk("mid_ir_clear", {16'h0, instr}, 32'h0);
        chk("mid_restart_req", {31'h0, i_readM}, 32'h1);
        chk("mid_restart_addr", {16'h0, i_address}, 32'h0);
        @(negedge clk);
        chk("mid_no_load", {16'h0, instr}, 32'h0);
        chk("mid_no_valid", {31'h0, instr_valid}, 32'h0);

        @(negedge clk);
        b_reset = 1'b0;
        b_exp_pc = 8'hFF;
        for (int k = 0; k < 257; k++) begin
            n = 0;
            while (!b_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("wrap_valid", {31'h0, b_valid}, 32'h1);
            chk("wrap_pc", {24'h0, b_pc}, {24'h0, b_exp_pc});
            if (k == 0) begin
                chk("wrap_plus1_ff", {24'h0, b_pc_plus1}, 32'h00);
            end
            b_accept = 1'b1;
            @(negedge clk);
            b_accept = 1'b0;
            b_exp_pc = b_exp_pc + 8'h1;
            chk("wrap_cnt", {24'h0, b_count}, (k + 1) % 256);
            if (k == 0) begin
                chk("wrap_pc_00", {24'h0, b_pc}, 32'h00);
                chk("wrap_plus1_01", {24'h0, b_pc_plus1}, 32'h01);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream stage of the ALU control unit in the 16-bit multi-cycle TSC CPU.
- Holds the PC, fetches one instruction per handshake from instruction memory (readM/inputReady protocol), and latches it into the instruction register.
- Presents IR to decode/ALU control with a valid/accept handshake.
- Applies the next-PC (sequential or redirect) and halt decisions returned by the execute stage.

Parameters:
WORD_SIZE, 16, instruction/address/data width
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
i_readM  output  1  instruction memory read request
i_address  output  WORD_SIZE  instruction memory address (= pc)
i_data  input  WORD_SIZE  instruction memory read data, valid when i_inputReady=1
i_inputReady  input  1  memory read-complete strobe, one cycle
instr  output  WORD_SIZE  instruction register contents, to decode and ALU control
instr_valid  output  1  instr holds a fetched, not-yet-consumed instruction
instr_accept  input  1  downstream has completed the instruction in instr
redirect  input  1  take redirect_pc as next PC (branch/JMP/JAL/JPR/JRL taken)
redirect_pc  input  WORD_SIZE  next-PC target
halt  input  1  current instruction is HLT; stop fetching
pc  output  WORD_SIZE  address of the instruction in instr / being fetched
pc_plus1  output  WORD_SIZE  pc+1, modulo 2^16, for JAL/JRL link value
fetch_count  output  WORD_SIZE  number of instructions accepted since reset

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, on port reset.
- States: S_INIT, S_REQ, S_VALID, S_HALT. All outputs are decoded from registered state. No combinational path from any input to any output.
- Reset (async, takes effect immediately, including mid-fetch):
  - state=S_INIT, pc=RESET_PC, IR=0, fetch_count=0.
  - i_readM=0, instr_valid=0.
  - Any in-flight memory read is abandoned; an i_inputReady arriving after reset is ignored.
- S_INIT: i_readM=0. Next cycle goes to S_REQ unconditionally. The first request therefore appears on the first rising edge after reset deasserts.
- S_REQ:
  - i_readM=1, i_address=pc, instr_valid=0.
  - When i_inputReady=1 at a rising edge: IR<=i_data, go to S_VALID.
  - Otherwise stay in S_REQ. Memory latency is unbounded.
- S_VALID:
  - i_readM=0, instr_valid=1, instr=IR.
  - Without instr_accept: hold all state; IR, pc and pc_plus1 stay stable.
  - With instr_accept=1 at a rising edge:
    - fetch_count<=fetch_count+1 (wraps FFFF->0000).
    - If halt=1: go to S_HALT; pc unchanged. halt has priority over redirect.
    - Else if redirect=1: pc<=redirect_pc, go to S_REQ.
    - Else: pc<=pc+1, go to S_REQ.
- S_HALT: i_readM=0, instr_valid=0. IR and pc are held. Leaves only on reset.
- Ignored inputs:
  - redirect, redirect_pc and halt are sampled only when state=S_VALID and instr_accept=1.
  - instr_accept is ignored outside S_VALID.
  - i_inputReady is ignored outside S_REQ.
- Latency: at least 2 cycles per instruction (S_REQ with immediate inputReady, then S_VALID with immediate accept).
- Arithmetic: pc+1 wraps 16'hFFFF -> 16'h0000. pc_plus1 = pc+1 combinationally, with the same wrap.
- instr holds its last value whenever instr_valid=0.

Test Plan:
- Reset then sequential fetch: reset pulse; memory returns 16'h6001 after 2 wait cycles -> readM=1 with address=0000 from the first post-reset edge; instr=6001, instr_valid=1; accept with redirect=0 -> pc=0001, readM=1, fetch_count=1.
- Redirect: at pc=0005, accept with redirect=1, redirect_pc=0x0020 (halt=0) -> next request has address=0020, pc_plus1=0021; redirect asserted while in S_REQ, and while in S_VALID without accept, leaves pc unchanged.
- Stall/hold: instr_valid=1, instr_accept held 0 for 5 cycles while i_inputReady toggles -> instr, pc and fetch_count unchanged, readM=0 throughout.
- Halt priority: accept with halt=1 and redirect=1, redirect_pc=0x0030 -> S_HALT, readM=0, instr_valid=0, pc unchanged, fetch_count incremented once; no further requests for 20 cycles.
- Wrap-around: RESET_PC=16'hFFFF; fetch and accept one instruction -> pc=0000, pc_plus1=0001; fetch_count at FFFF + accept -> 0000.
- Reset mid-fetch: assert reset between clock edges while readM=1 -> readM drops to 0 before the next edge; a late i_inputReady=1 with i_data=16'hBEEF does not load IR (IR=0); fetching restarts at RESET_PC.
